// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise AND/OR/XOR/NOT into a 2-entry result FIFO, 1-cycle latency; in_ready from registered occupancy only.
// Optional macro LOGIC_CHAIN_EN adds in_chain and a chain register that can replace operand A with the last accepted result.

// fifo: generic 2-entry FIFO with a reset value for storage; pop_dat is the head entry.
// Latency 1 cycle; push_rdy is a function of registered state only.
module fifo #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e         state, state_nxt;
  logic         wr_ptr, rd_ptr;
  logic [W-1:0] mem [2];
  logic         push, pop;

  assign push = push_vld & push_rdy;
  assign pop  = pop_vld & pop_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE:     if (push && !pop) state_nxt = FULL;
               else if (pop && !push) state_nxt = EMPTY;
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    push_rdy = 1'b1;
    pop_vld  = 1'b0;
    case (state)
      EMPTY:   begin push_rdy = 1'b1; pop_vld = 1'b0; end
      ONE:     begin push_rdy = 1'b1; pop_vld = 1'b1; end
      FULL:    begin push_rdy = 1'b0; pop_vld = 1'b1; end
      default: begin push_rdy = 1'b0; pop_vld = 1'b0; end
    endcase
  end

  // Storage is reset too so the head shows RST_VAL straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= RST_VAL;
      mem[1] <= RST_VAL;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef LOGIC_CHAIN_EN
  input  logic             in_chain,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  typedef struct packed {
    logic             zero;
    logic [WIDTH-1:0] data;
  } res_t;

  localparam res_t RST_RES = '{zero: 1'b1, data: '0};

  logic [WIDTH-1:0] op_a, res;
  res_t             push_dat, head;

`ifdef LOGIC_CHAIN_EN
  logic             accept;
  logic [WIDTH-1:0] chain_q;

  assign accept = in_valid & in_ready;
  assign op_a   = in_chain ? chain_q : in_a;

  // Tracks the last accepted result regardless of whether it has left the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n)      chain_q <= '0;
    else if (accept) chain_q <= res;
  end
`else
  assign op_a = in_a;
`endif

  always_comb begin
    res = '0;
    case (in_op)
      2'b00:   res = op_a & in_b;
      2'b01:   res = op_a | in_b;
      2'b10:   res = op_a ^ in_b;
      default: res = ~op_a;
    endcase
  end

  assign push_dat = '{zero: ~|res, data: res};

  fifo #(.W($bits(res_t)), .RST_VAL(RST_RES)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (push_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head)
  );

  assign out_data = head.data;
  assign out_zero = head.zero;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8): expected results queued on accept, compared at the FIFO head.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic             zero;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_chain = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int               checks = 0;
  int               passes = 0;
  int               fails  = 0;
  ent_t             sb[$];
  logic [WIDTH-1:0] chain_m = '0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef LOGIC_CHAIN_EN
    .in_chain  (in_chain),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Checks the outputs for the current cycle, then advances one edge and updates the model.
  task automatic cycle();
    logic             push, pop;
    logic [WIDTH-1:0] a_eff, r;
    chk("in_ready", in_ready, sb.size() < 2);
    chk("out_valid", out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      chk("out_data", out_data, sb[0].data);
      chk("out_zero", out_zero, sb[0].zero);
    end
    a_eff = in_a;
`ifdef LOGIC_CHAIN_EN
    if (in_chain) a_eff = chain_m;
`endif
    r    = model(in_op, a_eff, in_b);
    push = in_valid && (sb.size() < 2);
    pop  = out_ready && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      chain_m = '0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        sb.push_back('{zero: (r == '0), data: r});
        chain_m = r;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ch, input logic rdy);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_chain  = ch;
    out_ready = rdy;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_zero"}, out_zero, 1'b1);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    // Reset: raw edges, outputs are unknown before the first reset edge.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;

    // Single AND beat with out_ready=1: one-cycle out_valid pulse of 0x30.
    drive(1, 2'b00, 8'hF0, 8'h3C, 0, 1); cycle();
    chk("and_data", out_data, 8'h30);
    chk("and_zero", out_zero, 1'b0);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 1); cycle();
    chk("and_pulse_end", out_valid, 1'b0);
    cycle();

    // Fill: XOR FF^FF then OR 0F|A0, consumer stalled.
    drive(1, 2'b10, 8'hFF, 8'hFF, 0, 0); cycle();
    drive(1, 2'b01, 8'h0F, 8'hA0, 0, 0); cycle();
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_head", out_data, 8'h00);
    chk("full_head_zero", out_zero, 1'b1);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 0); cycle();
    chk("hold_head", out_data, 8'h00);

    // FULL with a beat held: one pop cycle, beat taken on the following edge.
    drive(1, 2'b00, 8'hAA, 8'h0F, 0, 1); cycle();
    chk("after_pop_head", out_data, 8'hAF);
    chk("after_pop_in_ready", in_ready, 1'b1);
    out_ready = 0; cycle();
    chk("refull_in_ready", in_ready, 1'b0);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 1); cycle();
    chk("drain_head", out_data, 8'h0A);
    cycle(); cycle();

    // ONE state: simultaneous push (NOT 0x55) and pop keeps occupancy at 1.
    drive(1, 2'b01, 8'h12, 8'h01, 0, 0); cycle();
    drive(1, 2'b11, 8'h55, 8'hC3, 0, 1); cycle();
    chk("one_out_valid", out_valid, 1'b1);
    chk("one_in_ready", in_ready, 1'b1);
    chk("one_head", out_data, 8'hAA);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 1); cycle(); cycle();

`ifdef LOGIC_CHAIN_EN
    drive(1, 2'b00, 8'hFF, 8'h3C, 0, 0); cycle();
    drive(1, 2'b10, 8'h00, 8'h0F, 1, 0); cycle();
    chk("chain_first", out_data, 8'h3C);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 1); cycle();
    chk("chain_second", out_data, 8'h33);
    cycle(); cycle();
`endif

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle();
    end

    // Reset while FULL with a beat offered on the reset edge.
    drive(1, 2'b01, 8'h11, 8'h22, 0, 0); cycle(); cycle(); cycle();
    chk("pre_rst_full", in_ready, 1'b0);
    drive(1, 2'b00, 8'hFF, 8'hFF, 0, 1);
    rst_n = 1'b0; cycle();
    reset_checks("midrst");
    rst_n = 1'b1;
    drive(1, 2'b10, 8'h5A, 8'h0F, 0, 1); cycle();
    chk("post_rst_data", out_data, 8'h55);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 1); cycle();
    chk("post_rst_only_one", out_valid, 1'b0);
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B; ignored for NOT.
REQ-009 in_chain  input  1  replace A with the chain register; present only with LOGIC_CHAIN_EN.
REQ-010 out_valid  output  1  result available at head of output buffer.
REQ-011 out_ready  input  1  consumer takes head result this cycle.
REQ-012 out_data  output  WIDTH  head result.
REQ-013 out_zero  output  1  head result is all zeros.

Function
REQ-014 Beat accepted on an edge where in_valid=1 and in_ready=1; result popped on an edge where out_valid=1 and out_ready=1.
REQ-015 Result: AND a&b, OR a|b, XOR a^b, NOT ~a, all bitwise across WIDTH bits; no carries, no sign handling.
REQ-016 Result is computed combinationally from the accepted beat and written into a 2-entry FIFO on the accepting edge.
REQ-017 Latency: a beat accepted at edge N has out_valid=1 from the cycle after edge N if the FIFO was empty, i.e. 1 cycle.
REQ-018 in_ready = (occupancy < 2), driven from registered occupancy only, with no combinational path from out_ready.
REQ-019 out_valid = (occupancy > 0); out_data and out_zero reflect the oldest entry; out_zero is stored with each entry.
REQ-020 Occupancy states EMPTY(0), ONE(1), FULL(2). Transitions: push only +1; pop only -1; push and pop together unchanged.
REQ-021 FULL: in_ready=0 and no push; a pop moves the state to ONE, and in_ready=1 the next cycle.
REQ-022 EMPTY: out_valid=0, and out_ready is ignored.
REQ-023 Order is strictly FIFO; read and write pointers wrap modulo 2.
REQ-024 out_data and out_zero hold stable while out_valid=1 and out_ready=0.
REQ-025 in_op, in_a, in_b and in_chain are sampled only on the accepting edge; values at any other time are don't-care.

Reset
REQ-026 When rst_n=0 at an edge: occupancy and pointers go to 0, out_valid=0, out_data=0, out_zero=1, in_ready=1 on the next cycle, and the chain register is 0.
REQ-027 Reset mid-operation discards all buffered results with no pop. Beats offered on the reset edge are not accepted.

Configuration
REQ-028 Macro LOGIC_CHAIN_EN defined: a WIDTH-bit chain register loads the result of every accepted beat.
REQ-029 With LOGIC_CHAIN_EN and in_chain=1 on accept: operand A is the chain register value, not in_a. The value is the last accepted result, whether or not it has been popped.
REQ-030 LOGIC_CHAIN_EN undefined: no in_chain port and no chain register; operand A is always in_a.

Verification
REQ-031 WIDTH=8, out_ready=1. Offer AND A=0xF0, B=0x3C -> next cycle out_data=0x30, out_zero=0, and a single out_valid pulse.
REQ-032 out_ready=0. Push XOR 0xFF^0xFF and then OR 0x0F|0xA0 -> in_ready=0 after the 2nd accept. Head=0x00 with out_zero=1. After pop, head=0xAF.
REQ-033 FULL with in_valid=1 held. Assert out_ready for 1 cycle -> 0x00 popped, and the offered beat is accepted one cycle later. No result is lost or duplicated.
REQ-034 ONE state, push NOT A=0x55 and pop together -> occupancy stays 1 and new head=0xAA.
REQ-035 LOGIC_CHAIN_EN. Accept AND 0xFF&0x3C, then XOR chain with B=0x0F and in_chain=1 -> results 0x3C, then 0x33.
REQ-036 FULL, drive rst_n=0 for one edge -> out_valid=0, out_data=0, out_zero=1, in_ready=1. A following beat yields only its own result.
